// File: rtl/flush_ctrl.sv
// Pipeline redirect/flush controller: turns resolved EX-stage branch, jump and exception
// information into PC redirects, pipeline flush lines, debug pulses and event counters.
module flush_ctrl #(
   parameter int unsigned          PC_WIDTH     = 32,
   parameter int unsigned          FLUSH_CYCLES = 2,
   parameter int unsigned          CNT_WIDTH    = 16,
   parameter logic [PC_WIDTH-1:0]  EXC_VECTOR   = 32'h0000_0010
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ex_valid,
   input  logic                 ex_is_branch,
   input  logic                 ex_is_jump,
   input  logic                 ex_taken,
   input  logic [PC_WIDTH-1:0]  ex_target,
   input  logic                 exc_req,
   input  logic                 exc_clear,
   output logic                 pc_redirect,
   output logic [PC_WIDTH-1:0]  pc_target,
   output logic                 flush_if_id,
   output logic                 flush_id_ex,
   output logic                 debug_is_bj,
   output logic                 debug_flush,
   output logic                 debug_exception,
   output logic [CNT_WIDTH-1:0] branch_count,
   output logic [CNT_WIDTH-1:0] flush_count
);

   localparam int unsigned          RemWidth = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [RemWidth-1:0]  RemInit  = RemWidth'(FLUSH_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

   typedef enum logic [1:0] {StIdle, StFlush, StExc} state_e;

   state_e                state_q, state_d;
   logic [RemWidth-1:0]   rem_q, rem_d;
   logic                  redirect_q, redirect_d;
   logic [PC_WIDTH-1:0]   target_q, target_d;
   logic                  flush_q, flush_d;
   logic                  is_bj_q, is_bj_d;
   logic                  exc_q, exc_d;
   logic [CNT_WIDTH-1:0]  bcount_q, bcount_d;
   logic [CNT_WIDTH-1:0]  fcount_q, fcount_d;
   logic                  bcount_inc, fcount_inc;
   logic                  bj_evt, take;

   assign bj_evt = ex_valid & (ex_is_jump | ex_is_branch);
   assign take   = ex_valid & (ex_is_jump | (ex_is_branch & ex_taken));

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      redirect_d = 1'b0;
      target_d   = target_q;
      flush_d    = flush_q;
      is_bj_d    = 1'b0;
      exc_d      = exc_q;
      bcount_inc = 1'b0;
      fcount_inc = 1'b0;

      // An exception outranks any branch/jump, including one squashed mid-flush.
      if (state_q != StExc && exc_req) begin
         state_d    = StExc;
         redirect_d = 1'b1;
         target_d   = EXC_VECTOR;
         flush_d    = 1'b1;
         exc_d      = 1'b1;
         fcount_inc = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               flush_d = 1'b0;
               exc_d   = 1'b0;
               if (take) begin
                  state_d    = StFlush;
                  redirect_d = 1'b1;
                  target_d   = ex_target;
                  flush_d    = 1'b1;
                  rem_d      = RemInit;
                  is_bj_d    = 1'b1;
                  bcount_inc = 1'b1;
                  fcount_inc = 1'b1;
               end else if (bj_evt) begin
                  is_bj_d    = 1'b1;
                  bcount_inc = 1'b1;
               end
            end
            StFlush: begin
               if (rem_q == '0) begin
                  state_d = StIdle;
                  flush_d = 1'b0;
               end else begin
                  rem_d   = rem_q - RemWidth'(1);
                  flush_d = 1'b1;
               end
            end
            StExc: begin
               flush_d = 1'b1;
               exc_d   = 1'b1;
               if (exc_clear) begin
                  state_d = StIdle;
                  flush_d = 1'b0;
                  exc_d   = 1'b0;
               end
            end
            default: begin
               state_d = StIdle;
               flush_d = 1'b0;
               exc_d   = 1'b0;
            end
         endcase
      end

      bcount_d = (bcount_inc && bcount_q != CntMax) ? bcount_q + CNT_WIDTH'(1) : bcount_q;
      fcount_d = (fcount_inc && fcount_q != CntMax) ? fcount_q + CNT_WIDTH'(1) : fcount_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         rem_q      <= '0;
         redirect_q <= 1'b0;
         target_q   <= '0;
         flush_q    <= 1'b0;
         is_bj_q    <= 1'b0;
         exc_q      <= 1'b0;
         bcount_q   <= '0;
         fcount_q   <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         flush_q    <= flush_d;
         is_bj_q    <= is_bj_d;
         exc_q      <= exc_d;
         bcount_q   <= bcount_d;
         fcount_q   <= fcount_d;
      end
   end

   assign pc_redirect     = redirect_q;
   assign pc_target       = target_q;
   assign flush_if_id     = flush_q;
   assign flush_id_ex     = flush_q;
   assign debug_flush     = flush_q;
   assign debug_is_bj     = is_bj_q;
   assign debug_exception = exc_q;
   assign branch_count    = bcount_q;
   assign flush_count     = fcount_q;

endmodule

// File: tb/tb_flush_ctrl.sv
// Directed bench for flush_ctrl: default instance plus a 4-bit-counter, 1-cycle-flush instance.
module tb_flush_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken;
   logic [31:0] ex_target;
   logic        exc_req, exc_clear;

   logic        pc_redirect, flush_if_id, flush_id_ex, debug_is_bj, debug_flush, debug_exception;
   logic [31:0] pc_target;
   logic [15:0] branch_count, flush_count;

   logic        s_redirect, s_flush_if_id, s_flush_id_ex, s_is_bj, s_flush, s_exc;
   logic [31:0] s_target;
   logic [3:0]  s_bcount, s_fcount;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   flush_ctrl dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
      .exc_req(exc_req), .exc_clear(exc_clear), .pc_redirect(pc_redirect),
      .pc_target(pc_target), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .debug_is_bj(debug_is_bj), .debug_flush(debug_flush),
      .debug_exception(debug_exception), .branch_count(branch_count),
      .flush_count(flush_count)
   );

   flush_ctrl #(.CNT_WIDTH(4), .FLUSH_CYCLES(1)) dut_sat (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
      .exc_req(exc_req), .exc_clear(exc_clear), .pc_redirect(s_redirect),
      .pc_target(s_target), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
      .debug_is_bj(s_is_bj), .debug_flush(s_flush), .debug_exception(s_exc),
      .branch_count(s_bcount), .flush_count(s_fcount)
   );

   typedef struct {
      logic        valid, br, jmp, taken;
      logic [31:0] tgt;
      logic        exc, clr;
      logic        e_redir;
      logic [31:0] e_tgt;
      logic        e_fl, e_bj, e_exc;
      logic [15:0] e_bc, e_fc;
      logic        e_sat_fl;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mk(logic valid, logic br, logic jmp, logic taken, logic [31:0] tgt,
                               logic exc, logic clr, logic e_redir, logic [31:0] e_tgt,
                               logic e_fl, logic e_bj, logic e_exc, logic [15:0] e_bc,
                               logic [15:0] e_fc, logic e_sat_fl);
      vec_t v;
      v.valid = valid; v.br = br; v.jmp = jmp; v.taken = taken; v.tgt = tgt;
      v.exc = exc; v.clr = clr; v.e_redir = e_redir; v.e_tgt = e_tgt; v.e_fl = e_fl;
      v.e_bj = e_bj; v.e_exc = e_exc; v.e_bc = e_bc; v.e_fc = e_fc; v.e_sat_fl = e_sat_fl;
      return v;
   endfunction

   function automatic logic [127:0] obs();
      return 128'({pc_redirect, pc_target, flush_if_id, flush_id_ex, debug_flush,
                   debug_is_bj, debug_exception, branch_count, flush_count});
   endfunction

   function automatic logic [127:0] want(logic redir, logic [31:0] tgt, logic fl, logic bj,
                                         logic exc, logic [15:0] bc, logic [15:0] fc);
      return 128'({redir, tgt, fl, fl, fl, bj, exc, bc, fc});
   endfunction

   function automatic logic [127:0] sat_obs();
      return 128'({s_redirect, s_target, s_flush_if_id, s_flush_id_ex, s_flush, s_is_bj,
                   s_exc, s_bcount, s_fcount});
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive(input logic valid, input logic br, input logic jmp, input logic taken,
                        input logic [31:0] tgt, input logic exc, input logic clr);
      ex_valid = valid; ex_is_branch = br; ex_is_jump = jmp; ex_taken = taken;
      ex_target = tgt; exc_req = exc; exc_clear = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = mk(1,0,1,0,32'h100,0,0, 1,32'h100,1,1,0,1,1, 1);
      vecs[1]  = mk(1,1,0,1,32'h200,0,0, 0,32'h100,1,0,0,1,1, 0);
      vecs[2]  = mk(0,0,0,0,32'h0,  0,0, 0,32'h100,0,0,0,1,1, 0);
      vecs[3]  = mk(1,1,0,0,32'h0,  0,0, 0,32'h100,0,1,0,2,1, 0);
      vecs[4]  = mk(1,1,0,0,32'h0,  0,0, 0,32'h100,0,1,0,3,1, 0);
      vecs[5]  = mk(1,1,0,0,32'h0,  0,0, 0,32'h100,0,1,0,4,1, 0);
      vecs[6]  = mk(0,0,0,0,32'h0,  0,0, 0,32'h100,0,0,0,4,1, 0);
      vecs[7]  = mk(1,0,1,0,32'h300,1,0, 1,32'h10, 1,0,1,4,2, 1);
      vecs[8]  = mk(1,0,1,0,32'h300,1,0, 0,32'h10, 1,0,1,4,2, 1);
      vecs[9]  = mk(0,0,0,0,32'h0,  0,1, 0,32'h10, 0,0,0,4,2, 0);
      vecs[10] = mk(1,1,0,1,32'h400,0,0, 1,32'h400,1,1,0,5,3, 1);
      vecs[11] = mk(0,0,0,0,32'h0,  1,0, 1,32'h10, 1,0,1,5,4, 1);
      vecs[12] = mk(0,0,0,0,32'h0,  0,0, 0,32'h10, 1,0,1,5,4, 1);
      vecs[13] = mk(0,0,0,0,32'h0,  0,0, 0,32'h10, 1,0,1,5,4, 1);
      vecs[14] = mk(0,0,0,0,32'h0,  0,1, 0,32'h10, 0,0,0,5,4, 0);
      vecs[15] = mk(0,0,0,0,32'h0,  0,1, 0,32'h10, 0,0,0,5,4, 0);
      vecs[16] = mk(0,0,1,0,32'h999,0,0, 0,32'h10, 0,0,0,5,4, 0);
      vecs[17] = mk(1,0,1,0,32'h500,0,0, 1,32'h500,1,1,0,6,5, 1);
      vecs[18] = mk(1,0,1,0,32'h600,0,0, 0,32'h500,1,0,0,6,5, 0);
      vecs[19] = mk(0,0,0,0,32'h0,  0,0, 0,32'h500,0,0,0,6,5, 0);

      reset = 1'b1;
      drive(0,0,0,0,32'h0,0,0);
      tick(); tick();
      check("reset_state", obs(), 128'(0));
      reset = 1'b0;
      tick();
      check("idle_after_reset", obs(), 128'(0));

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].valid, vecs[i].br, vecs[i].jmp, vecs[i].taken, vecs[i].tgt,
               vecs[i].exc, vecs[i].clr);
         tick();
         check($sformatf("vec%0d", i), obs(),
               want(vecs[i].e_redir, vecs[i].e_tgt, vecs[i].e_fl, vecs[i].e_bj, vecs[i].e_exc,
                    vecs[i].e_bc, vecs[i].e_fc));
         check($sformatf("vec%0d_sat_flush", i), 128'(s_flush_if_id), 128'(vecs[i].e_sat_fl));
      end

      // Reset in the middle of a flush clears everything at once.
      drive(1,0,1,0,32'h700,0,0);
      tick();
      check("pre_reset_flush", obs(), want(1,32'h700,1,1,0,7,6));
      drive(0,0,0,0,32'h0,0,0);
      reset = 1'b1;
      #1;
      check("reset_async", obs(), 128'(0));
      check("reset_async_sat", sat_obs(), 128'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_hold%0d", i), obs(), 128'(0));
      end
      reset = 1'b0;
      tick();
      check("post_reset_idle", obs(), 128'(0));

      drive(1,0,1,0,32'h800,0,0);
      tick();
      check("post_reset_jump", obs(), want(1,32'h800,1,1,0,1,1));
      drive(0,0,0,0,32'h0,0,0);
      tick();
      check("post_reset_flush2", obs(), want(0,32'h800,1,0,0,1,1));
      tick();
      check("post_reset_flush_end", obs(), want(0,32'h800,0,0,0,1,1));

      // 20 not-taken branches: 4-bit counter saturates at 15, 16-bit keeps counting.
      for (int n = 1; n <= 20; n++) begin
         drive(1,1,0,0,32'h0,0,0);
         tick();
         check($sformatf("nt_branch%0d", n), obs(),
               want(0,32'h800,0,1,0,16'(1 + n),1));
         check($sformatf("sat_count%0d", n), 128'(s_bcount),
               128'((1 + n) > 15 ? 15 : (1 + n)));
      end
      drive(0,0,0,0,32'h0,0,0);
      tick();
      check("sat_hold", sat_obs(), 128'({1'b0, 32'h800, 3'b000, 1'b0, 1'b0, 4'hf, 4'h1}));
      check("main_after_sat", obs(), want(0,32'h800,0,0,0,21,1));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
- Pipeline control block that produces the CPU's redirect, flush and debug event signals (debug_is_bj, debug_flush, debug_exception).
- Takes resolved branch/jump and exception information from the EX stage.
- Drives the IF/ID and ID/EX flush lines and the PC redirect.
- Holds saturating branch and flush event counters, so simulation and debug logic can count events exactly instead of edge-detecting.

Parameters:
PC_WIDTH, 32, width of PC and target addresses
FLUSH_CYCLES, 2, cycles flush lines stay high after a taken branch/jump (>=1)
CNT_WIDTH, 16, width of the event counters
EXC_VECTOR, 32'h0000_0010, redirect target on exception

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX stage holds a valid instruction this cycle
ex_is_branch  in  1  EX instruction is a conditional branch
ex_is_jump  in  1  EX instruction is JAL/JALR
ex_taken  in  1  branch condition resolved true (ignored for jumps)
ex_target  in  PC_WIDTH  resolved branch/jump target
exc_req  in  1  exception raised in pipeline this cycle
exc_clear  in  1  exception handled, leave exception state
pc_redirect  out  1  one-cycle pulse: load pc_target into PC
pc_target  out  PC_WIDTH  redirect address, valid with pc_redirect
flush_if_id  out  1  squash IF/ID register
flush_id_ex  out  1  squash ID/EX register
debug_is_bj  out  1  one-cycle pulse per accepted branch/jump
debug_flush  out  1  equals flush_if_id
debug_exception  out  1  high while in EXC state
branch_count  out  CNT_WIDTH  accepted branch/jump events, saturating
flush_count  out  CNT_WIDTH  flush episodes (FLUSH or EXC entries), saturating

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, pc_target 0, both counters 0, flush counter 0. Reset mid-flush aborts immediately; outputs go to 0 while reset is high.
- All outputs are registered. Latency is 1 cycle from the input cycle to the output.
- bj_evt = ex_valid & (ex_is_jump | ex_is_branch). take = ex_valid & (ex_is_jump | (ex_is_branch & ex_taken)).
- IDLE state:
  - exc_req: go to EXC; pc_redirect=1; pc_target=EXC_VECTOR; flush lines high; flush_count++. A simultaneous bj_evt is squashed: not counted, no debug_is_bj.
  - else take: go to FLUSH; pc_redirect=1; pc_target=ex_target; flush lines high; remaining flush cycles=FLUSH_CYCLES-1; debug_is_bj=1; branch_count++; flush_count++.
  - else bj_evt (not-taken branch): debug_is_bj=1; branch_count++; no flush. Back-to-back not-taken branches give a debug_is_bj that stays high over consecutive cycles.
- FLUSH state:
  - Flush lines stay high for exactly FLUSH_CYCLES cycles in total.
  - ex_valid/bj inputs are ignored, because those instructions are squashed.
  - exc_req has priority: go to EXC with the same actions as in IDLE. The flush lines stay high continuously.
  - When the remaining count reaches 0, go to IDLE and drop the flush lines in the next cycle.
- EXC state:
  - Flush lines and debug_exception are held high.
  - pc_redirect is low after its single pulse.
  - exc_req and bj inputs are ignored.
  - exc_clear: go to IDLE; flush lines and debug_exception drop next cycle.
- pc_redirect is never high in two consecutive cycles, except FLUSH→EXC where the exception redirect overrides.
- pc_target holds its last value when pc_redirect=0.
- Counters saturate at all-ones and never wrap.
- FLUSH_CYCLES=1: the flush is a single cycle and the block returns to IDLE the cycle after.

Test Plan:
1. Reset: assert reset for 3 cycles mid-run, including during a flush → every output 0 within the same cycle; branch_count=flush_count=0 after release.
2. Jump: ex_valid=1, ex_is_jump=1, ex_target=0x100, FLUSH_CYCLES=2 → next cycle pc_redirect=1, pc_target=0x100, debug_is_bj=1 for 1 cycle; flush_if_id/flush_id_ex/debug_flush high exactly 2 cycles; branch_count=1, flush_count=1.
3. Not-taken branches: 3 consecutive cycles with ex_is_branch=1, ex_taken=0 → debug_is_bj high 3 consecutive cycles, no flush, no redirect; branch_count=3, flush_count=0.
4. Squash during flush: taken branch, then a branch with ex_valid=1 in the following cycle → the second branch is ignored; branch_count=1, debug_is_bj single pulse.
5. Exception priority: exc_req together with a taken jump in IDLE → pc_target=0x10, debug_exception=1, branch_count unchanged. Then exc_req during a FLUSH → EXC entry, flush_count increments. Flush stays high until exc_clear, then drops 1 cycle later.
6. Saturation: CNT_WIDTH=4, 20 not-taken branches → branch_count=15 and holds.
